// File: rtl/bcd_scorekeeper_n.sv
`default_nettype none
// ============================================================================
// Module   : bcd_scorekeeper_n
// Purpose  : N-digit packed-BCD score register, stepped up/down digit-serially
//            on each debounced button rise. SCORE_SAT_EN selects saturation
//            instead of modulo-10^DIGITS wrap.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_scorekeeper_n #(
    parameter int DIGITS = 3,
    parameter int STEP_W = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  btn,
    input  logic                  dir,
    input  logic [STEP_W-1:0]     step,
    output logic [4*DIGITS-1:0]   digits,
    output logic                  busy,
    output logic                  done,
    output logic                  ovf
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;

    logic [1:0]            state;
    logic [1:0]            state_nxt;
    logic                  btn_q;
    logic                  rise;
    logic                  pending;
    logic                  dir_q;
    logic [3:0]            carry;
    logic [IDX_W-1:0]      idx;
    logic [4*DIGITS-1:0]   shadow;
    logic [4*DIGITS-1:0]   shadow_nxt;
    logic [4*DIGITS-1:0]   digits_q;
    logic [4*DIGITS-1:0]   result;
    logic                  done_q;
    logic                  ovf_q;
    logic [3:0]            cur_d;
    logic [3:0]            new_d;
    logic                  new_c;
    logic [4:0]            sum;
    logic signed [4:0]     diff;

    assign rise = btn & ~btn_q;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (rise || pending) state_nxt = S_RUN;
            S_RUN:    if (idx == LAST_IDX) state_nxt = S_COMMIT;
            S_COMMIT: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy   = (state != S_IDLE);
        done   = done_q;
        ovf    = ovf_q;
        digits = digits_q;
    end

    // Select the digit currently being worked on
    always_comb begin
        cur_d = 4'd0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx == IDX_W'(k)) cur_d = shadow[4*k +: 4];
        end
    end

    // One BCD digit step; the first carry may be as large as 7
    always_comb begin
        sum   = {1'b0, cur_d} + {1'b0, carry};
        diff  = $signed({1'b0, cur_d}) - $signed({1'b0, carry});
        new_d = cur_d;
        new_c = 1'b0;
        if (!dir_q) begin
            if (sum >= 5'd10) begin
                new_d = 4'(sum - 5'd10);
                new_c = 1'b1;
            end else begin
                new_d = sum[3:0];
            end
        end else begin
            if (diff < 5'sd0) begin
                new_d = 4'(diff + 5'sd10);
                new_c = 1'b1;
            end else begin
                new_d = diff[3:0];
            end
        end
    end

    always_comb begin
        shadow_nxt = shadow;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx == IDX_W'(k)) shadow_nxt[4*k +: 4] = new_d;
        end
    end

    // Value written at commit; carry holds the final carry/borrow by then
`ifdef SCORE_SAT_EN
    always_comb begin
        if (carry[0]) begin
            result = dir_q ? '0 : {DIGITS{4'h9}};
        end else begin
            result = shadow;
        end
    end
`else
    always_comb begin
        result = shadow;
    end
`endif

    // ---------------- Datapath ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_q    <= btn;
            pending  <= 1'b0;
            dir_q    <= 1'b0;
            carry    <= 4'd0;
            idx      <= '0;
            shadow   <= '0;
            digits_q <= '0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            btn_q  <= btn;
            done_q <= 1'b0;
            ovf_q  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (rise || pending) begin
                        dir_q   <= dir;
                        carry   <= 4'(step);
                        idx     <= '0;
                        shadow  <= digits_q;
                        pending <= 1'b0;
                    end
                end
                S_RUN: begin
                    shadow <= shadow_nxt;
                    carry  <= {3'b000, new_c};
                    idx    <= idx + IDX_W'(1);
                    if (rise) pending <= 1'b1;
                end
                S_COMMIT: begin
                    digits_q <= result;
                    done_q   <= 1'b1;
                    ovf_q    <= carry[0];
                    if (rise) pending <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/bcd_scorekeeper_n.md
# bcd_scorekeeper_n

Parametrised successor to the three-digit scorekeeper: an N-digit packed-BCD score register, stepped up or down by a switch-selected amount on each rising edge of a debounced button. Arithmetic is digit-serial, one BCD digit per clock, through a small FSM. Outputs feed the seven-segment display multiplexer directly and never show a partially updated value. It sits between the debouncer and the display block on the slow clock domain.

## Interface
- DIGITS, 3: number of BCD digits, 1..8.
- STEP_W, 3: width of `step`, 1..3, so the maximum step is 7.
- clk  in  1: slow system clock.
- rst  in  1: synchronous, active-high reset.
- btn  in  1: debounced button level. A rising edge requests one update.
- dir  in  1: 0 = add step, 1 = subtract step. Sampled when the request is accepted.
- step  in  STEP_W: binary step amount. Sampled when the request is accepted.
- digits  out  4*DIGITS: packed BCD value. Digit k (k=0 is ones) is at [4k+3:4k].
- busy  out  1: high while an update is in progress (RUN or COMMIT).
- done  out  1: one-cycle pulse when `digits` takes its new value.
- ovf  out  1: one-cycle pulse, coincident with `done`, when the update wrapped or saturated.

## Operation
- Edge detect: `btn_q` register. `rise = btn & ~btn_q`. During reset, `btn_q` loads `btn`, so a button held through reset does not count.
- Reset values: digits=0, busy=0, done=0, ovf=0, pending=0, state=IDLE.
- States:
  - IDLE: on `rise` or `pending`, latch `step` and `dir`, set carry=step, idx=0, shadow=digits, clear pending, go to RUN.
  - RUN: process digit `idx` in shadow, then idx++. After digit DIGITS-1, go to COMMIT.
    - Up: t = d + c. If t ≥ 10, then d' = t−10 and c = 1; otherwise d' = t and c = 0.
    - Down: t = d − c. If t < 0, then d' = t+10 and c = 1; otherwise d' = t and c = 0.
    - The initial carry can be up to 7. From digit 1 onward the carry is 0 or 1.
  - COMMIT: final carry=1 means overflow/underflow. Write the result to `digits`, assert done, assert ovf=final carry, go to IDLE.
- Result is wrap modulo 10^DIGITS by default; see Configuration for saturation.
- Request arriving while busy: sets `pending` (one-deep). Further rises while pending=1 are dropped. On return to IDLE, a pending request starts immediately and samples `step`/`dir` at that cycle.
- step=0: full sequence runs, digits unchanged, done pulses, ovf=0.
- All digit values stay in 0..9. Internal add/sub uses 5-bit signed intermediates.

## Timing
- Let edge E be the first edge at which btn=1 with btn_q=0.
  - Edge E: IDLE→RUN.
  - Edges E+1..E+DIGITS: process the digits.
  - Edge E+DIGITS+1: COMMIT→IDLE, and digits/done/ovf update.
- Latency is DIGITS+1 edges after acceptance. done and ovf are high for exactly the cycle after that edge.
- busy is high from edge E to edge E+DIGITS+1.
- Back-to-back: a pending request leaves IDLE on the edge after COMMIT, so throughput is one update per DIGITS+2 cycles.
- Reset mid-operation aborts the update: digits go to 0 and the pending request is lost. A `rise` coincident with reset is ignored.

## Configuration
- SCORE_SAT_EN defined:
  - On up-overflow, digits become all 9s.
  - On down-underflow, digits become all 0s.
  - ovf still pulses.
- SCORE_SAT_EN undefined: the result wraps modulo 10^DIGITS, and ovf pulses on wrap.

## Test plan
- DIGITS=3, reset, dir=0, step=3, three btn pulses -> digits=009. Each done is DIGITS+1 edges after acceptance. ovf=0.
- Preload to 999 via pulses, step=1, up, without SCORE_SAT_EN -> 000 with ovf=1. With SCORE_SAT_EN -> 999 with ovf=1.
- Value 100, dir=1, step=1 -> 099. Value 003, dir=1, step=5: wrap build -> 998 with ovf=1; SCORE_SAT_EN build -> 000 with ovf=1.
- Three rises within one busy window, step=2, up, from 000 -> exactly two updates -> 004, two done pulses.
- rst asserted on the second RUN cycle of an update from 050 -> digits=000, busy=0, no done. btn held high through the reset release -> no update.
- step=0 pulse at 123 -> done pulses, digits=123, ovf=0.
